// File: rtl/merge_240hz_if.sv
// merge_240hz_if: received byte stream in, decoded 240 Hz / 60 Hz samples out.
// The byte source (UART RX side) is the master; the decoder is the slave.
interface merge_240hz_if #(
  parameter int UART_BIT_WIDTH  = 8,
  parameter int FRAME_BIT_WIDTH = 32,
  parameter int POSTI_BIT_WIDTH = 16
);
  logic [UART_BIT_WIDTH-1:0]  iData;
  logic                       iValid;
  logic                       oSubValid;
  logic [FRAME_BIT_WIDTH-1:0] oSubFrame;
  logic [POSTI_BIT_WIDTH-1:0] oSubPosti;
  logic                       oValid;
  logic [FRAME_BIT_WIDTH-1:0] oFrame;
  logic [POSTI_BIT_WIDTH+1:0] oPosti;
  logic                       oSeqErr;
  logic                       oTimeout;

  modport master (
    output iData, iValid,
    input  oSubValid, oSubFrame, oSubPosti,
    input  oValid, oFrame, oPosti, oSeqErr, oTimeout
  );

  modport slave (
    input  iData, iValid,
    output oSubValid, oSubFrame, oSubPosti,
    output oValid, oFrame, oPosti, oSeqErr, oTimeout
  );
endinterface

// File: rtl/merge_240hz.sv
// merge_240hz: hunts for the header byte in the UART byte stream, reassembles
// each sub-packet (frame field + signed position quotient) into a 240 Hz sample,
// and merges every in-order run of sub-indices 0..3 into one 60 Hz sample.
module merge_240hz #(
  parameter int                        UART_BIT_WIDTH  = 8,
  parameter logic [UART_BIT_WIDTH-1:0] HEADER          = 8'hFF,
  parameter int                        FRAME_BIT_WIDTH = 32,
  parameter int                        POSTI_BIT_WIDTH = 16,
  parameter int                        TIMEOUT         = 1024
) (
  input logic          clk,
  input logic          rst,
  merge_240hz_if.slave bus
);

  localparam int FRAME_BYTES = FRAME_BIT_WIDTH / UART_BIT_WIDTH;
  localparam int POSTI_BYTES = POSTI_BIT_WIDTH / UART_BIT_WIDTH;
  localparam int MAX_BYTES   = (FRAME_BYTES > POSTI_BYTES) ? FRAME_BYTES : POSTI_BYTES;
  localparam int CNT_W       = $clog2(MAX_BYTES + 1);
  localparam int IDLE_W      = $clog2(TIMEOUT + 1);
  localparam int SUM_W       = POSTI_BIT_WIDTH + 2;

  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0]  POSTI_LAST = CNT_W'(POSTI_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_FRAME,
    ST_POSTI
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [CNT_W-1:0]           r_cnt;
  logic [IDLE_W-1:0]          r_idle;
  logic [FRAME_BIT_WIDTH-1:0] r_frame;
  logic [POSTI_BIT_WIDTH-1:0] r_posti;

  logic [1:0]                 r_exp;
  logic [FRAME_BIT_WIDTH-1:0] r_gbase;
  logic [SUM_W-1:0]           r_acc;

  logic                       r_subValid;
  logic [FRAME_BIT_WIDTH-1:0] r_subFrame;
  logic [POSTI_BIT_WIDTH-1:0] r_subPosti;
  logic                       r_valid;
  logic [FRAME_BIT_WIDTH-1:0] r_oFrame;
  logic [SUM_W-1:0]           r_oPosti;
  logic                       r_seqErr;
  logic                       r_timeout;

  logic                       w_accept;
  logic                       w_isHeader;
  logic                       w_idleLast;
  logic                       w_complete;
  logic                       w_timeoutHit;
  logic [POSTI_BIT_WIDTH-1:0] w_postiFull;
  logic [SUM_W-1:0]           w_postiExt;
  logic [1:0]                 w_idx;
  logic [FRAME_BIT_WIDTH-1:0] w_base;
  logic                       w_inOrder;
  logic [SUM_W-1:0]           w_sum;

  assign w_accept   = bus.iValid;
  assign w_isHeader = (bus.iData == HEADER);
  assign w_idleLast = !w_accept && (r_idle == IDLE_LAST);

  // Position value as it will look once the byte on iData is shifted in;
  // on the final position byte this is the complete quotient.
  assign w_postiFull = {bus.iData, r_posti[POSTI_BIT_WIDTH-1:UART_BIT_WIDTH]};
  assign w_postiExt  = {{2{w_postiFull[POSTI_BIT_WIDTH-1]}}, w_postiFull};

  // The frame field is already fully assembled while position bytes arrive.
  assign w_idx     = r_frame[1:0];
  assign w_base    = r_frame >> 2;
  assign w_inOrder = (w_idx == r_exp) && ((w_idx == 2'd0) || (w_base == r_gbase));
  assign w_sum     = ((w_idx == 2'd0) ? SUM_W'(0) : r_acc) + w_postiExt;

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Parser next-state: header hunt, frame bytes, position bytes, idle abort.
  always_comb begin
    w_stateNext  = r_state;
    w_complete   = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_accept && w_isHeader) begin
          w_stateNext = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (w_accept) begin
          if (r_cnt == FRAME_LAST) begin
            w_stateNext = ST_POSTI;
          end
        end else if (w_idleLast) begin
          w_stateNext  = ST_HUNT;
          w_timeoutHit = 1'b1;
        end
      end
      ST_POSTI: begin
        if (w_accept) begin
          if (r_cnt == POSTI_LAST) begin
            w_stateNext = ST_HUNT;
            w_complete  = 1'b1;
          end
        end else if (w_idleLast) begin
          w_stateNext  = ST_HUNT;
          w_timeoutHit = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_HUNT;
      end
    endcase
  end

  // Byte counter and inter-byte idle counter for the sub-packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idle <= '0;
    end else begin
      if ((r_state == ST_HUNT) || w_timeoutHit || w_complete) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if ((r_state == ST_FRAME) && (r_cnt == FRAME_LAST)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if ((r_state == ST_HUNT) || w_accept || w_timeoutHit) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  // Payload shift registers, least significant byte arrives first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_posti <= '0;
    end else begin
      if ((r_state == ST_FRAME) && w_accept) begin
        r_frame <= {bus.iData, r_frame[FRAME_BIT_WIDTH-1:UART_BIT_WIDTH]};
      end
      if ((r_state == ST_POSTI) && w_accept) begin
        r_posti <= w_postiFull;
      end
    end
  end

  // Sub-packet outputs and the four-packet group merger.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp      <= '0;
      r_gbase    <= '0;
      r_acc      <= '0;
      r_subValid <= 1'b0;
      r_subFrame <= '0;
      r_subPosti <= '0;
      r_valid    <= 1'b0;
      r_oFrame   <= '0;
      r_oPosti   <= '0;
      r_seqErr   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_subValid <= 1'b0;
      r_valid    <= 1'b0;
      r_seqErr   <= 1'b0;
      r_timeout  <= w_timeoutHit;

      if (w_timeoutHit) begin
        r_exp <= '0;
        r_acc <= '0;
      end else if (w_complete) begin
        r_subValid <= 1'b1;
        r_subFrame <= r_frame;
        r_subPosti <= w_postiFull;
        if (w_inOrder) begin
          r_acc   <= w_sum;
          r_gbase <= w_base;
          if (w_idx == 2'd3) begin
            r_exp    <= '0;
            r_valid  <= 1'b1;
            r_oFrame <= w_base;
            r_oPosti <= w_sum;
          end else begin
            r_exp <= r_exp + 2'd1;
          end
        end else begin
          r_seqErr <= 1'b1;
          if (w_idx == 2'd0) begin
            r_acc   <= w_postiExt;
            r_gbase <= w_base;
            r_exp   <= 2'd1;
          end else begin
            r_exp <= '0;
            r_acc <= '0;
          end
        end
      end
    end
  end

  assign bus.oSubValid = r_subValid;
  assign bus.oSubFrame = r_subFrame;
  assign bus.oSubPosti = r_subPosti;
  assign bus.oValid    = r_valid;
  assign bus.oFrame    = r_oFrame;
  assign bus.oPosti    = r_oPosti;
  assign bus.oSeqErr   = r_seqErr;
  assign bus.oTimeout  = r_timeout;

endmodule

// File: tb/tb_merge_240hz.sv
// tb_merge_240hz: directed bench for the sub-packet decoder and group merger.
module tb_merge_240hz;

  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;
  int subCnt      = 0;
  int grpCnt      = 0;
  int errCnt      = 0;
  int toCnt       = 0;
  int alignErr    = 0;

  always #5 clk = ~clk;

  merge_240hz_if #(
    .UART_BIT_WIDTH (8),
    .FRAME_BIT_WIDTH(32),
    .POSTI_BIT_WIDTH(16)
  ) bus ();

  merge_240hz #(
    .UART_BIT_WIDTH (8),
    .HEADER         (8'hFF),
    .FRAME_BIT_WIDTH(32),
    .POSTI_BIT_WIDTH(16),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Tally output pulses mid-cycle; group and error pulses must ride on a sub-packet pulse.
  always @(negedge clk) begin
    if (bus.oSubValid === 1'b1) subCnt++;
    if (bus.oValid === 1'b1) begin
      grpCnt++;
      if (bus.oSubValid !== 1'b1) alignErr++;
    end
    if (bus.oSeqErr === 1'b1) begin
      errCnt++;
      if (bus.oSubValid !== 1'b1) alignErr++;
    end
    if (bus.oTimeout === 1'b1) toCnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.iData  = b;
    bus.iValid = 1'b1;
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.iValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendPacket(input logic [31:0] frame, input logic [15:0] posti);
    applyStimulus(8'hFF);
    for (int i = 0; i < 4; i++) applyStimulus(frame[8*i +: 8]);
    for (int i = 0; i < 2; i++) applyStimulus(posti[8*i +: 8]);
  endtask

  task automatic checkSub(input string tag, input logic [31:0] frame, input logic [15:0] posti,
                          input logic expValid, input logic expErr);
    checkOutput({tag, ".subValid"}, 64'(bus.oSubValid), 64'(1'b1));
    checkOutput({tag, ".subFrame"}, 64'(bus.oSubFrame), 64'(frame));
    checkOutput({tag, ".subPosti"}, 64'(bus.oSubPosti), 64'(posti));
    checkOutput({tag, ".valid"},    64'(bus.oValid),    64'(expValid));
    checkOutput({tag, ".seqErr"},   64'(bus.oSeqErr),   64'(expErr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".subValid"}, 64'(bus.oSubValid), 64'd0);
    checkOutput({tag, ".subFrame"}, 64'(bus.oSubFrame), 64'd0);
    checkOutput({tag, ".subPosti"}, 64'(bus.oSubPosti), 64'd0);
    checkOutput({tag, ".valid"},    64'(bus.oValid),    64'd0);
    checkOutput({tag, ".frame"},    64'(bus.oFrame),    64'd0);
    checkOutput({tag, ".posti"},    64'(bus.oPosti),    64'd0);
    checkOutput({tag, ".seqErr"},   64'(bus.oSeqErr),   64'd0);
    checkOutput({tag, ".timeout"},  64'(bus.oTimeout),  64'd0);
  endtask

  // Directed sequence: reset, merged group, garbage/payload FF, sequence errors,
  // idle timeout boundary, mid-packet reset, base mismatch.
  initial begin
    rst        = 1'b1;
    bus.iData  = 8'h00;
    bus.iValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      sendPacket(32'h28 + 32'(k), 16'hFFFD);
      checkSub($sformatf("grp1.%0d", k), 32'h28 + 32'(k), 16'hFFFD, (k == 3), 1'b0);
    end
    checkOutput("grp1.frame", 64'(bus.oFrame), 64'd10);
    checkOutput("grp1.posti", 64'(bus.oPosti), 64'h3FFF4);
    idle(1);
    checkOutput("grp1.subPulse", 64'(bus.oSubValid), 64'd0);
    checkOutput("grp1.validPulse", 64'(bus.oValid), 64'd0);

    applyStimulus(8'h00);
    applyStimulus(8'h12);
    sendPacket(32'h00FF00FF, 16'h0010);
    checkSub("payloadFF", 32'h00FF00FF, 16'h0010, 1'b0, 1'b1);
    idle(2);
    checkOutput("payloadFF.count", 64'(subCnt), 64'd5);

    sendPacket(32'h80, 16'h0001);
    checkSub("skip.0", 32'h80, 16'h0001, 1'b0, 1'b0);
    sendPacket(32'h81, 16'h0002);
    checkSub("skip.1", 32'h81, 16'h0002, 1'b0, 1'b0);
    sendPacket(32'h83, 16'h0003);
    checkSub("skip.3", 32'h83, 16'h0003, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      sendPacket(32'h84 + 32'(k), 16'h7FFF);
      checkSub($sformatf("grpMax.%0d", k), 32'h84 + 32'(k), 16'h7FFF, (k == 3), 1'b0);
    end
    checkOutput("grpMax.frame", 64'(bus.oFrame), 64'h21);
    checkOutput("grpMax.posti", 64'(bus.oPosti), 64'h1FFFC);

    applyStimulus(8'hFF);
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    idle(TIMEOUT - 1);
    checkOutput("idleShort.timeout", 64'(bus.oTimeout), 64'd0);
    applyStimulus(8'h00);
    idle(TIMEOUT - 1);
    checkOutput("idleEdge.timeout", 64'(bus.oTimeout), 64'd0);
    idle(1);
    checkOutput("idleFull.timeout", 64'(bus.oTimeout), 64'd1);
    idle(1);
    checkOutput("idleFull.pulse", 64'(bus.oTimeout), 64'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    applyStimulus(8'h00);
    idle(2);
    checkOutput("afterTimeout.count", 64'(subCnt), 64'd12);
    sendPacket(32'h44, 16'h0007);
    checkSub("afterTimeout", 32'h44, 16'h0007, 1'b0, 1'b0);

    applyStimulus(8'hFF);
    applyStimulus(8'h50);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midReset");
    rst = 1'b0;
    applyStimulus(8'h02);
    for (int k = 0; k < 4; k++) begin
      sendPacket(32'h54 + 32'(k), 16'h8000);
      checkSub($sformatf("grpMin.%0d", k), 32'h54 + 32'(k), 16'h8000, (k == 3), 1'b0);
    end
    checkOutput("grpMin.frame", 64'(bus.oFrame), 64'h15);
    checkOutput("grpMin.posti", 64'(bus.oPosti), 64'h20000);

    sendPacket(32'h14, 16'h0005);
    checkSub("baseMis.0", 32'h14, 16'h0005, 1'b0, 1'b0);
    sendPacket(32'h19, 16'h0006);
    checkSub("baseMis.1", 32'h19, 16'h0006, 1'b0, 1'b1);
    idle(3);

    checkOutput("total.sub", 64'(subCnt), 64'd19);
    checkOutput("total.group", 64'(grpCnt), 64'd3);
    checkOutput("total.seqErr", 64'(errCnt), 64'd3);
    checkOutput("total.timeout", 64'(toCnt), 64'd1);
    checkOutput("total.align", 64'(alignErr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
